// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared widths, FSM states and operand-pair type for the multiplier sequencer
package mult_seq_pkg;
  localparam int OPW = 4;
  localparam int PW  = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } pair_t;
endpackage

// File: rtl/mult_seq_fifo.sv
// rtl/mult_seq_fifo.sv - synchronous operand-pair FIFO, power-of-two depth
module mult_seq_fifo
  import mult_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rstn,
  input  logic  push,
  input  pair_t wdata,
  input  logic  pop,
  output pair_t rdata,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  pair_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - operand sequencer, result capture and watchdog for the 4x4 shift-add multiplier
// MULT_SEQ_ACC_EN adds the acc_out running sum of delivered products.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int TIMEOUT_CYC = 15
`ifdef MULT_SEQ_ACC_EN
  , parameter int ACC_W     = 12
`endif
) (
  input  logic           CK,
  input  logic           RSTN,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  output logic           START,
  output logic [OPW-1:0] A,
  output logic [OPW-1:0] B,
  input  logic           READY,
  input  logic [PW-1:0]  P,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  out_p,
  output logic           busy,
  output logic           timeout_err
`ifdef MULT_SEQ_ACC_EN
  , output logic [ACC_W-1:0] acc_out
`endif
);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  state_t         state;
  pair_t          in_pair;
  pair_t          head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           load;
  logic [WDW-1:0] wdog;

  assign in_pair  = '{a: in_a, b: in_b};
  assign load     = (state == IDLE) && !fifo_empty;
  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;

  mult_seq_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CK),
    .rstn  (RSTN),
    .push  (in_valid),
    .wdata (in_pair),
    .pop   (load),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // wdog counts completed WAIT cycles, so wdog==0 marks the first one where READY may be stale
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state       <= IDLE;
      START       <= 1'b0;
      A           <= '0;
      B           <= '0;
      out_valid   <= 1'b0;
      out_p       <= '0;
      timeout_err <= 1'b0;
      wdog        <= '0;
    end else begin
      START <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            A     <= head.a;
            B     <= head.b;
            START <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + 1'b1;
          if ((wdog != '0) && READY) begin
            out_p     <= P;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (wdog == WDW'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_SEQ_ACC_EN
  always_ff @(posedge CK) begin
    if (!RSTN)                         acc_out <= '0;
    else if (out_valid && out_ready)   acc_out <= acc_out + ACC_W'(out_p);
  end
`endif
endmodule
